// File: rtl/jio_input.sv
// Input-side device for the jcscpu I/O bus: a debounced button latches the
// switches into a one-byte holding register that the CPU reads with IN.
module jio_input #(
  parameter logic [7:0]  DEV_ADDR        = 8'h01,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       io_s,
  input  logic       io_e,
  input  logic       io_da,
  input  logic       io_io,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  input  logic [7:0] sw,
  input  logic       btn,
  output logic       ready,
  output logic       overrun
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  logic             sel, rdd, rds, selected, consume;
  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             sel_q, sel_d, sel_prev_q, sel_prev_d;
  logic             rdd_q, rdd_d, rdd_prev_q, rdd_prev_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             overrun_q, overrun_d;
  state_e           state_q, state_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    sel      = io_s & io_da & io_io;
    rdd      = io_e & ~io_da & ~io_io;
    rds      = io_e & io_da & ~io_io;
    selected = (addr_q == DEV_ADDR);

    sync_d = {sync_q[0], btn};
    db_d   = db_q;
    cnt_d  = cnt_q;
    // Count only while the synchronized button disagrees with the accepted level;
    // any return to agreement restarts the stability window.
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = db_d & ~db_q;

    sel_d      = sel;
    sel_prev_d = sel_q;
    addr_d     = (sel_q & ~sel_prev_q) ? bus_in : addr_q;

    // Byte leaves the register only once the CPU's read strobe has ended.
    rdd_d      = rdd & selected;
    rdd_prev_d = rdd_q;
    consume    = rdd_prev_q & ~rdd_q;

    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    case (state_q)
      EMPTY: begin
        if (press_q) begin
          state_d   = FULL;
          data_d    = sw;
          overrun_d = 1'b0;
        end
      end
      FULL: begin
        if (press_q && consume) begin
          data_d    = sw;
          overrun_d = 1'b0;
        end else if (press_q) begin
          overrun_d = 1'b1;
        end else if (consume) begin
          state_d   = EMPTY;
          overrun_d = 1'b0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      // NOTE: the holding register is reset too, so a read after reset is 0, not X.
      sync_q     <= '0;
      db_q       <= 1'b0;
      cnt_q      <= '0;
      press_q    <= 1'b0;
      sel_q      <= 1'b0;
      sel_prev_q <= 1'b0;
      rdd_q      <= 1'b0;
      rdd_prev_q <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      overrun_q  <= 1'b0;
      state_q    <= EMPTY;
    end else begin
      sync_q     <= sync_d;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
      sel_q      <= sel_d;
      sel_prev_q <= sel_prev_d;
      rdd_q      <= rdd_d;
      rdd_prev_q <= rdd_prev_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
    end
  end

  assign ready   = (state_q == FULL);
  assign overrun = overrun_q;

  always_comb begin
    bus_out = 8'h00;
    if (rdd && selected) begin
      bus_out = (state_q == FULL) ? data_q : 8'h00;
    end else if (rds && selected) begin
      bus_out = {overrun_q, 6'b0, ready};
    end
  end

endmodule

// File: tb/tb_jio_input.sv
// Bench for jio_input: directed test-plan scenarios plus random traffic, all
// outputs scoreboarded every cycle against a history-based behavioural model.
module tb_jio_input;

  localparam int         DC  = 4;
  localparam logic [7:0] DEV = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_s = 1'b0, io_e = 1'b0, io_da = 1'b0, io_io = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] sw = 8'h00;
  logic       btn = 1'b0;
  logic [7:0] bus_out;
  logic       ready, overrun;

  int n_vec = 0;
  int n_err = 0;

  jio_input #(.DEV_ADDR(DEV), .DEBOUNCE_CYCLES(DC)) dut (
    .CLK(clk), .RESETN(rst_n),
    .io_s(io_s), .io_e(io_e), .io_da(io_da), .io_io(io_io),
    .bus_in(bus_in), .bus_out(bus_out),
    .sw(sw), .btn(btn), .ready(ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Button: the accepted level becomes v once the last DC synchronizer outputs
  // (raw samples delayed two clocks) all read v; a rise is seen by the holding
  // register one clock later. Reads consume two clocks after the strobe ends.
  bit         hist[$];
  bit         m_db, m_press_pend, m_full, m_ovr;
  bit         m_sel1, m_sel2, m_rdd1, m_rdd2;
  logic [7:0] m_addr, m_data;
  logic [9:0] exp_q[$];

  function automatic void reset_model();
    hist.delete();
    repeat (DC + 1) hist.push_back(1'b0);
    m_db = 0; m_press_pend = 0; m_full = 0; m_ovr = 0;
    m_sel1 = 0; m_sel2 = 0; m_rdd1 = 0; m_rdd2 = 0;
    m_addr = 8'h00; m_data = 8'h00;
  endfunction

  function automatic void model_edge();
    bit sel_now, rdd_now, consume, press, same, v;
    sel_now = io_s & io_da & io_io;
    rdd_now = io_e & ~io_da & ~io_io & (m_addr == DEV);
    consume = !m_rdd1 && m_rdd2;
    press   = m_press_pend;
    if (press && consume) begin
      m_data = sw; m_full = 1; m_ovr = 0;
    end else if (press) begin
      if (m_full) m_ovr = 1;
      else begin m_full = 1; m_data = sw; end
    end else if (consume) begin
      m_full = 0; m_ovr = 0;
    end
    v = hist[0];
    same = 1;
    for (int i = 0; i < DC; i++) if (hist[i] != v) same = 0;
    m_press_pend = same && v && !m_db;
    if (same) m_db = v;
    if (m_sel1 && !m_sel2) m_addr = bus_in;
    m_sel2 = m_sel1; m_sel1 = sel_now;
    m_rdd2 = m_rdd1; m_rdd1 = rdd_now;
    hist.push_back(btn);
    void'(hist.pop_front());
  endfunction

  function automatic logic [9:0] expected_out();
    logic [7:0] b;
    bit sel_ok;
    sel_ok = (m_addr == DEV);
    b = 8'h00;
    if (io_e && !io_da && !io_io && sel_ok) b = m_full ? m_data : 8'h00;
    else if (io_e && io_da && !io_io && sel_ok) b = {m_ovr, 6'b0, m_full};
    return {m_full, m_ovr, b};
  endfunction

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else model_edge();
    end
  end

  initial forever begin
    @(negedge clk);
    exp_q.push_back(expected_out());
  end

  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard {ready,overrun,bus_out}", {22'b0, ready, overrun, bus_out}, {22'b0, e});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    io_s = 0; io_e = 0; io_da = 0; io_io = 0;
  endtask

  task automatic set_sel(input logic [7:0] a);
    io_s = 1; io_e = 0; io_da = 1; io_io = 1; bus_in = a;
  endtask

  task automatic set_rdd();
    io_s = 0; io_e = 1; io_da = 0; io_io = 0;
  endtask

  task automatic set_rds();
    io_s = 0; io_e = 1; io_da = 1; io_io = 0;
  endtask

  task automatic do_sel(input logic [7:0] a);
    set_sel(a); step(4); set_idle(); step(1);
  endtask

  task automatic press_hold(input logic [7:0] val);
    sw = val; btn = 1; step(10); btn = 0; step(8);
  endtask

  task automatic wait_ready(input int budget, output int cyc);
    cyc = 0;
    while (!ready && cyc < budget) begin
      step(1);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int btn_left, stb_left;
    step(3);
    rst_n = 1;
    step(2);
    check("reset ready", ready, 0);
    check("reset overrun", overrun, 0);
    check("reset bus_out", bus_out, 0);

    // First capture and its latency
    sw = 8'hA5; btn = 1;
    wait_ready(20, cyc);
    check("press latency", cyc, 7);
    check("overrun after first press", overrun, 0);
    step(3); btn = 0; step(8);

    // Selected data read, then consume
    do_sel(8'h01);
    set_rdd(); step(1);
    check("rdd data", bus_out, 8'hA5);
    step(4); set_idle(); step(1);
    check("ready 1 clk after rdd", ready, 1);
    step(1);
    check("ready 2 clk after rdd", ready, 0);
    check("bus idle after rdd", bus_out, 0);

    // Deselected read does nothing
    press_hold(8'hA5);
    do_sel(8'h00);
    set_rdd(); step(1);
    check("deselected rdd", bus_out, 8'h00);
    step(3); set_idle(); step(4);
    check("ready after deselected rdd", ready, 1);

    // Overrun status
    do_sel(8'h01);
    press_hold(8'h3C);
    set_rds(); step(1);
    check("status overrun", bus_out, 8'h81);
    set_idle(); step(1);
    set_rdd(); step(1);
    check("rdd keeps old byte", bus_out, 8'hA5);
    step(2); set_idle(); step(4);
    set_rds(); step(1);
    check("status after consume", bus_out, 8'h00);
    set_idle(); step(1);

    // Bounce rejected, then press coinciding with consume
    press_hold(8'h5A);
    repeat (3) begin btn = 1; step(2); btn = 0; step(2); end
    check("bounce no overrun", overrun, 0);
    sw = 8'hC3; btn = 1; step(1);
    set_rdd(); step(1);
    check("rdd before coincident consume", bus_out, 8'h5A);
    step(3); set_idle(); step(4);
    check("coincident ready", ready, 1);
    check("coincident overrun", overrun, 0);
    set_rdd(); step(1);
    check("coincident new byte", bus_out, 8'hC3);
    set_idle(); step(4);
    btn = 0; step(8);

    // Reset mid-debounce while full
    press_hold(8'h77);
    set_rds(); btn = 1; step(3);
    rst_n = 0; #1;
    check("async reset ready", ready, 0);
    check("async reset overrun", overrun, 0);
    check("async reset bus_out", bus_out, 0);
    step(2); set_idle(); sw = 8'h99;
    rst_n = 1;
    wait_ready(20, cyc);
    check("press latency after reset", cyc, 7);
    step(15);
    check("single capture overrun", overrun, 0);
    do_sel(8'h01);
    set_rdd(); step(1);
    check("capture after reset", bus_out, 8'h99);
    set_idle(); btn = 0; step(8);

    // Random traffic, scoreboard only
    btn_left = 0; stb_left = 0;
    for (int i = 0; i < 500; i++) begin
      if (btn_left == 0) begin
        btn = ~btn;
        btn_left = $urandom_range(1, 9);
        if ($urandom_range(0, 2) == 0) sw = 8'($urandom);
      end
      btn_left--;
      if (stb_left == 0) begin
        case ($urandom_range(0, 4))
          0: set_idle();
          1: set_sel(($urandom_range(0, 3) == 0) ? 8'($urandom)
                     : (($urandom_range(0, 2) != 0) ? 8'h01 : 8'h00));
          2, 3: set_rdd();
          default: set_rds();
        endcase
        stb_left = $urandom_range(1, 6);
      end
      stb_left--;
      step(1);
    end
    set_idle(); btn = 0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
